// File: rtl/motor_pwm_pkg.sv
// Shared constants for the motor PWM block: register map offsets, bit positions and write decode kinds.
package motor_pwm_pkg;

  localparam int CH_BASE     = 0;
  localparam int CTRL_EN_BIT = 0;

  typedef enum logic [1:0] {
    WR_NONE,
    WR_CHAN,
    WR_PERIOD,
    WR_CTRL
  } wr_kind_e;

  function automatic int period_addr(input int num_ch);
    return num_ch;
  endfunction

  function automatic int ctrl_addr(input int num_ch);
    return num_ch + 1;
  endfunction

  function automatic int dir_bit(input int cnt_w);
    return cnt_w;
  endfunction

endpackage

// File: rtl/motor_pwm_timebase.sv
// Shared PWM timebase: prescaler, period counter and the tick/wrap strobes that drive shadow loading.
module motor_pwm_timebase #(
  parameter int CNT_W    = 16,
  parameter int PRESCALE = 50
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [CNT_W-1:0] active_period,
  output logic [CNT_W-1:0] cnt,
  output logic             tick,
  output logic             wrap
);

  localparam int              PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

  logic [PRE_W-1:0] presc_q, presc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick = enable && (presc_q == PRE_LAST);
  assign wrap = tick && (active_period != '0) && (cnt_q == (active_period - CNT_W'(1)));
  assign cnt  = cnt_q;

  // A zero period parks the counter at 0 so a later period write starts cleanly.
  always_comb begin
    presc_d = presc_q;
    cnt_d   = cnt_q;
    if (!enable) begin
      presc_d = '0;
      cnt_d   = '0;
    end else if (tick) begin
      presc_d = '0;
      if ((active_period == '0) || wrap) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      presc_d = presc_q + PRE_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q <= '0;
      cnt_q   <= '0;
    end else begin
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/motor_pwm.sv
// Multi-channel motor PWM with period-aligned shadow registers and a write watchdog.
// Watchdog is built only when MOTOR_PWM_WATCHDOG_EN is defined; otherwise wdog_tripped is 0.
module motor_pwm
  import motor_pwm_pkg::*;
#(
  parameter int NUM_CH      = 8,
  parameter int CNT_W       = 16,
  parameter int PRESCALE    = 50,
  parameter int WDOG_CYCLES = 25_000_000,
  parameter int ADDR_W      = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [31:0]       wr_data,
  output logic [NUM_CH-1:0] pwm_out,
  output logic [NUM_CH-1:0] dir_out,
  output logic              wdog_tripped
);

  localparam int               DIR_BIT  = dir_bit(CNT_W);
  localparam logic [ADDR_W-1:0] PERIOD_A = ADDR_W'(period_addr(NUM_CH));
  localparam logic [ADDR_W-1:0] CTRL_A   = ADDR_W'(ctrl_addr(NUM_CH));

  logic [CNT_W-1:0]  duty_sh_q [NUM_CH];
  logic [CNT_W-1:0]  duty_sh_d [NUM_CH];
  logic [CNT_W-1:0]  duty_act_q [NUM_CH];
  logic [CNT_W-1:0]  duty_act_d [NUM_CH];
  logic [NUM_CH-1:0] dir_sh_q, dir_sh_d;
  logic [NUM_CH-1:0] dir_act_q, dir_act_d;
  logic [CNT_W-1:0]  period_sh_q, period_sh_d;
  logic [CNT_W-1:0]  period_act_q, period_act_d;
  logic              enable_q, enable_d;
  logic [NUM_CH-1:0] pwm_q, pwm_d;
  logic [NUM_CH-1:0] dir_q, dir_d;

  logic [CNT_W-1:0]  cnt;
  logic              tick;
  logic              wrap;
  logic              wdog_trip;
  logic              load_active;
  logic              run;
  wr_kind_e          wr_kind;
  logic              unused_wr_data;

  assign unused_wr_data = ^wr_data[31:DIR_BIT+1];

  motor_pwm_timebase #(
    .CNT_W    (CNT_W),
    .PRESCALE (PRESCALE)
  ) u_timebase (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable_q),
    .active_period (period_act_q),
    .cnt           (cnt),
    .tick          (tick),
    .wrap          (wrap)
  );

  always_comb begin
    wr_kind = WR_NONE;
    if (wr_en) begin
      if (wr_addr < PERIOD_A) begin
        wr_kind = WR_CHAN;
      end else if (wr_addr == PERIOD_A) begin
        wr_kind = WR_PERIOD;
      end else if (wr_addr == CTRL_A) begin
        wr_kind = WR_CTRL;
      end
    end
  end

  always_comb begin
    duty_sh_d   = duty_sh_q;
    dir_sh_d    = dir_sh_q;
    period_sh_d = period_sh_q;
    enable_d    = enable_q;
    for (int i = 0; i < NUM_CH; i++) begin
      if ((wr_kind == WR_CHAN) && (wr_addr == ADDR_W'(CH_BASE + i))) begin
        duty_sh_d[i] = wr_data[CNT_W-1:0];
        dir_sh_d[i]  = wr_data[DIR_BIT];
      end
    end
    if (wr_kind == WR_PERIOD) begin
      period_sh_d = wr_data[CNT_W-1:0];
    end
    if (wr_kind == WR_CTRL) begin
      enable_d = wr_data[CTRL_EN_BIT];
    end
  end

  // Actives copy the pre-write shadow, so a write landing on a wrap waits one more period.
  assign load_active = !enable_q || wrap || (tick && (period_act_q == '0));

  always_comb begin
    duty_act_d   = duty_act_q;
    dir_act_d    = dir_act_q;
    period_act_d = period_act_q;
    if (load_active) begin
      duty_act_d   = duty_sh_q;
      dir_act_d    = dir_sh_q;
      period_act_d = period_sh_q;
    end
  end

  assign run = enable_q && (period_act_q != '0) && !wdog_trip;

  always_comb begin
    pwm_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      pwm_d[i] = run && (cnt < duty_act_q[i]);
    end
    dir_d = dir_act_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      duty_sh_q    <= '{default: '0};
      duty_act_q   <= '{default: '0};
      dir_sh_q     <= '0;
      dir_act_q    <= '0;
      period_sh_q  <= '0;
      period_act_q <= '0;
      enable_q     <= 1'b0;
      pwm_q        <= '0;
      dir_q        <= '0;
    end else begin
      duty_sh_q    <= duty_sh_d;
      duty_act_q   <= duty_act_d;
      dir_sh_q     <= dir_sh_d;
      dir_act_q    <= dir_act_d;
      period_sh_q  <= period_sh_d;
      period_act_q <= period_act_d;
      enable_q     <= enable_d;
      pwm_q        <= pwm_d;
      dir_q        <= dir_d;
    end
  end

`ifdef MOTOR_PWM_WATCHDOG_EN
  localparam int              WD_W    = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(WDOG_CYCLES - 1);

  logic [WD_W-1:0] wdog_cnt_q, wdog_cnt_d;
  logic            wdog_trip_q, wdog_trip_d;

  // Counter saturates at the trip point; any write, even to an unused address, rearms it.
  always_comb begin
    wdog_cnt_d  = wdog_cnt_q;
    wdog_trip_d = wdog_trip_q;
    if (wr_en) begin
      wdog_cnt_d  = '0;
      wdog_trip_d = 1'b0;
    end else if (wdog_cnt_q == WD_LAST) begin
      wdog_trip_d = 1'b1;
    end else begin
      wdog_cnt_d = wdog_cnt_q + WD_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wdog_cnt_q  <= '0;
      wdog_trip_q <= 1'b0;
    end else begin
      wdog_cnt_q  <= wdog_cnt_d;
      wdog_trip_q <= wdog_trip_d;
    end
  end

  assign wdog_trip = wdog_trip_q;
`else
  logic unused_wdog_cfg;
  assign unused_wdog_cfg = (WDOG_CYCLES > 0);
  assign wdog_trip       = 1'b0;
`endif

  assign pwm_out      = pwm_q;
  assign dir_out      = dir_q;
  assign wdog_tripped = wdog_trip;

endmodule

// File: doc/motor_pwm.md
# motor_pwm

Multi-channel PWM generator for the thruster/motor drivers. Holds per-channel duty and direction plus a shared period in software-written shadow registers, then produces registered PWM and direction levels that feed the global disable stage ahead of the GPIO pins. Shadow values become active only at a period boundary, so outputs never glitch. A watchdog forces all PWM low if software stops writing.

## Interface
- NUM_CH, 8: number of motor channels.
- CNT_W, 16: width of the duty, period and counter.
- PRESCALE, 50: clk cycles per PWM tick. Must be ≥1. The default gives 1 µs at 50 MHz.
- WDOG_CYCLES, 25_000_000: clk cycles without a write before the watchdog trips.
- ADDR_W, 4: write address width. Must satisfy 2^ADDR_W ≥ NUM_CH+2.

Ports:
- clk, in, 1: system clock.
- reset, in, 1: synchronous, active-high reset.
- wr_en, in, 1: single-cycle write strobe.
- wr_addr, in, ADDR_W: register select.
- wr_data, in, 32: write data.
- pwm_out, out, NUM_CH: PWM level per channel.
- dir_out, out, NUM_CH: direction per channel.
- wdog_tripped, out, 1: watchdog expired; sticky until the next write.

## Operation
Register map (write-only):
- Addresses 0..NUM_CH-1: channel word. wr_data[CNT_W-1:0] is the duty shadow and wr_data[CNT_W] is the direction shadow.
- Address NUM_CH: period shadow, from wr_data[CNT_W-1:0].
- Address NUM_CH+1: control. wr_data[0] is enable.
- Any other address: the write is ignored for storage but still kicks the watchdog.

Counting:
- A prescaler counts 0..PRESCALE-1. The tick pulse is asserted on the cycle the prescaler is at PRESCALE-1.
- On each tick, cnt increments. When cnt == active_period-1, cnt instead wraps to 0.
- On wrap, every active duty, direction and period is loaded from its shadow in the same cycle.

PWM output:
- pwm_out[i] = run && (cnt < active_duty[i]), registered.
- run = enable && (active_period != 0) && !wdog_tripped.
- Duty 0 gives constant low.
- Duty ≥ active_period gives constant high, with no single-cycle dip at wrap.

Disabled or zero-period handling:
- When enable is 0, the prescaler and cnt are held at 0. Actives are loaded from shadows every cycle and pwm_out is 0.
- Setting enable to 1 starts a fresh period at cnt 0 with the latest shadows.
- When enable is 1 and active_period is 0, cnt is held at 0 and actives reload from shadows on every tick. A later nonzero period write therefore starts within one tick.

Direction:
- dir_out follows the active direction, registered. It changes only at a wrap or while disabled.

Watchdog:
- Refer to Configuration for compile-time gating.
- A counter clears on any wr_en.
- When the counter reaches WDOG_CYCLES-1, wdog_tripped is set.
- wdog_tripped clears on the cycle after the next wr_en. PWM resumes from the current cnt, with no forced period restart.

Simultaneous events:
- A write on the wrap cycle updates only the shadow; the active copy receives the previous shadow value. The new value takes effect at the following wrap.
- A control write of 0 wins over a wrap in the same cycle.

## Timing
- Reset values: all shadows, actives, cnt, prescaler and watchdog counter are 0. pwm_out, dir_out and wdog_tripped are 0.
- pwm_out and dir_out lag the cnt/active state by 1 clk.
- Enable write to first pwm_out high: 2 clk, provided duty > 0 and period > 0 are already written.
- Period in clk cycles: active_period × PRESCALE. High time: min(duty, period) × PRESCALE.
- Watchdog trip to pwm_out low: 1 clk after wdog_tripped rises.
- Reset asserted mid-period forces all outputs to 0 on the next edge.

## Configuration
- MOTOR_PWM_WATCHDOG_EN defined: the watchdog counter and trip logic are built as described above.
- MOTOR_PWM_WATCHDOG_EN undefined: there is no watchdog counter, wdog_tripped is tied to 0, and run does not depend on it.

## Structure
- Shared package motor_pwm_pkg holds:
  - the address offsets CH_BASE=0, PERIOD_ADDR=NUM_CH and CTRL_ADDR=NUM_CH+1, as functions of NUM_CH;
  - the control bit index CTRL_EN_BIT=0;
  - the direction bit position, equal to CNT_W.
- One natural sub-module, motor_pwm_timebase, contains the prescaler, cnt, tick and wrap generation. It takes enable and active_period as inputs and outputs cnt, tick and wrap. Per-channel compare and shadow logic stay in the top level.

## Test plan
Bench settings: NUM_CH=2, CNT_W=8, PRESCALE=1, WDOG_CYCLES=100, watchdog enabled.

1. Write period=10, ch0 duty=3, ch1 duty=0, then enable=1. Required: pwm_out[0] is high 3 of every 10 cycles, starting 2 clk after the enable write, and pwm_out[1] stays 0.
2. While running, write ch0 duty=7 with dir=1 at cnt=4. Required: the current period keeps 3 high cycles and dir_out stays 0. From the next wrap, the pattern is 7 high per 10 and dir_out[0] is 1.
3. Write ch0 duty=10, then ch0 duty=255. Required: pwm_out[0] is continuously high across several wraps, with no low cycle.
4. Make no writes for 100 cycles. Required: wdog_tripped rises and pwm_out falls 1 clk later. One write to an unused address clears the trip and PWM resumes.
5. Write enable=0 mid-period. Required: pwm_out is 0 the next cycle and cnt is 0. Re-enabling restarts at cnt 0.
6. Assert reset mid-operation with period=10 and duty=5 running. Required: all outputs are 0. After release, no PWM appears until period, duty and enable are rewritten.
